modn_count_ctrl: RTL and testbench
==================================

# modn_count_ctrl

Command-driven controller that sequences a programmable modulo-N counter for the counter datapaths in this codebase. A requester issues a start command carrying a modulus and a wrap budget over a valid/ready handshake. The block runs the count, flags each terminal count, supports pause and abort, and pulses `done` when the wrap budget is spent. It sits between a control FSM or host register and any logic that consumes a bounded mod-N count sequence, for example a mod-6 sequence.

## Interface
- `WIDTH`, default 3: count width; legal modulus range is 2 .. 2^WIDTH-1.
- `WRAP_W`, default 8: width of the wrap budget and the internal wrap counter.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_mod`  in  WIDTH  requested modulus N.
- `cmd_wraps`  in  WRAP_W  number of full N-cycles to run; 0 means free-run until abort.
- `pause`  in  1  freezes counting while high.
- `abort`  in  1  cancels the run.
- `count`  out  WIDTH  current count value, registered.
- `tc`  out  1  terminal count: high while the count is on its last value and will wrap on this edge.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the wrap budget completes.
- `err`  out  1  one-cycle pulse when an illegal command is rejected.

## Operation
- FSM states are IDLE, RUN and DONE. `busy` = (state == RUN). `cmd_ready` = (state == IDLE).
- IDLE:
  - A command is accepted on an edge where `cmd_valid` && `cmd_ready`.
  - If `cmd_mod` < 2: register `err` = 1 for one cycle, stay in IDLE, and leave the latched modulus/wraps unchanged.
  - Otherwise: latch `mod_r` = `cmd_mod` and `wraps_r` = `cmd_wraps`, clear `count` and the wrap counter, go to RUN.
- RUN, on each edge with `pause` = 0:
  - If `count` == `mod_r` - 1: `count` goes to 0 and the wrap counter increments.
  - Otherwise `count` increments by 1.
  - If `wraps_r` != 0 and the wrap counter == `wraps_r` - 1 at a terminal count: go to DONE with `count` = 0.
- RUN with `pause` = 1: `count`, the wrap counter and the state all hold.
- `tc` is combinational: (state == RUN) && !`pause` && (`count` == `mod_r` - 1).
- DONE lasts exactly one cycle:
  - `done` = 1, `count` = 0, `cmd_ready` = 0.
  - Next state is IDLE unconditionally; `pause` and `abort` are ignored here.
- `abort` = 1 in RUN: next state IDLE, `count` = 0, wrap counter = 0, no `done` pulse.
- Priority: reset > `abort` > `pause` > count advance.
- Free-run (`wraps_r` == 0): the wrap counter wraps modulo 2^WRAP_W; it never terminates the run.
- `cmd_valid` outside IDLE is ignored and not queued. The requester must hold it until `cmd_ready`.
- Inputs are synchronous to `clk`; no internal synchronisers.

## Timing
- Reset values: state = IDLE, `count` = 0, `tc` = 0, `busy` = 0, `done` = 0, `err` = 0, `cmd_ready` = 1.
- Accept edge E0: the first RUN cycle follows it with `count` = 0. The count then advances once per unpaused edge.
- For modulus N and wraps W > 0 with no pause, RUN lasts exactly N·W cycles.
  - `tc` is high in RUN cycles k·N (k = 1..W).
  - `done` is high in cycle N·W + 1 after E0.
  - `cmd_ready` returns in the cycle after that.
- Each paused cycle extends the run by exactly one cycle.
- Minimum command-to-command spacing is N·W + 2 cycles.
- `err` rises in the cycle after the rejecting edge; `cmd_ready` stays high throughout.
- `abort` asserted in a cycle where `tc` = 1: the abort wins. There is no wrap, no `done`, and the block is in IDLE on the next cycle.
- Reset asserted mid-run: all outputs go to their reset values immediately, without waiting for a clock.

## Test plan
- Reset mid-RUN:
  - While running, assert `reset` low between edges -> `count` = 0, `busy` = 0, `cmd_ready` = 1 immediately.
  - Release and issue a new command -> accepted normally.
- Nominal run: `cmd_mod` = 6, `cmd_wraps` = 2 -> `count` sequence 0,1,2,3,4,5,0,1,2,3,4,5; `tc` in RUN cycles 6 and 12; `done` in cycle 13; `cmd_ready` = 1 in cycle 14.
- Pause: `cmd_mod` = 6, `cmd_wraps` = 1, `pause` high for 3 cycles while `count` = 3 -> `count` holds 3 and `tc` = 0 during the pause; `done` arrives 3 cycles later than the 7-cycle nominal.
- Abort at terminal count: `cmd_mod` = 5, `cmd_wraps` = 0, assert `abort` in a cycle with `count` = 4 -> no `done`; next cycle `count` = 0 and `cmd_ready` = 1.
- Illegal modulus and busy rejection:
  - `cmd_mod` = 1 in IDLE -> single-cycle `err`, state stays IDLE.
  - `cmd_valid` during RUN with `cmd_mod` = 3 -> ignored; the latched modulus is unchanged and the run completes per the original command.
- Max modulus: `cmd_mod` = 7, `cmd_wraps` = 3 -> counts 0..6 three times; 3 `tc` pulses; `done` in cycle 22.

Source files
------------

// File: rtl/modn_count_ctrl_if.sv
// Command channel of modn_count_ctrl: a valid/ready handshake carrying the
// requested modulus and wrap budget.
interface modn_count_ctrl_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WRAP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_mod;
    logic [WRAP_W-1:0] cmd_wraps;

    modport master (
        output cmd_valid,
        output cmd_mod,
        output cmd_wraps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mod,
        input  cmd_wraps,
        output cmd_ready
    );
endinterface

// File: rtl/modn_count_ctrl.sv
// Command-driven modulo-N counter sequencer: runs a wrap budget of N-cycles,
// flags terminal counts, and supports pause and abort.
module modn_count_ctrl #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WRAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    modn_count_ctrl_if.slave cmd,
    input  logic             i_pause,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_count, w_count_nxt;
    logic [WIDTH-1:0]  r_mod, w_mod_nxt;
    logic [WRAP_W-1:0] r_wraps, w_wraps_nxt;
    logic [WRAP_W-1:0] r_wrap_cnt, w_wrap_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic              w_last;
    logic              w_budget_end;

    assign w_last       = (r_count == r_mod - WIDTH'(1));
    // Free-run (zero budget) never terminates; the wrap counter just rolls over.
    assign w_budget_end = (r_wraps != '0) && (r_wrap_cnt == r_wraps - WRAP_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_mod_nxt      = r_mod;
        w_wraps_nxt    = r_wraps;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_err_nxt      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_mod < WIDTH'(2)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_mod_nxt      = cmd.cmd_mod;
                        w_wraps_nxt    = cmd.cmd_wraps;
                        w_count_nxt    = '0;
                        w_wrap_cnt_nxt = '0;
                        w_state_nxt    = StRun;
                    end
                end
            end
            StRun: begin
                if (i_abort) begin
                    w_count_nxt    = '0;
                    w_wrap_cnt_nxt = '0;
                    w_state_nxt    = StIdle;
                end else if (!i_pause) begin
                    if (w_last) begin
                        w_count_nxt    = '0;
                        w_wrap_cnt_nxt = r_wrap_cnt + WRAP_W'(1);
                        if (w_budget_end) begin
                            w_state_nxt = StDone;
                        end
                    end else begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end
            end
            StDone: begin
                w_count_nxt = '0;
                w_state_nxt = StIdle;
            end
            default: begin
                w_count_nxt = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_mod      <= '0;
            r_wraps    <= '0;
            r_wrap_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_mod      <= w_mod_nxt;
            r_wraps    <= w_wraps_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign cmd.cmd_ready = (r_state == StIdle);
    assign o_busy        = (r_state == StRun);
    assign o_done        = (r_state == StDone);
    assign o_count       = r_count;
    assign o_err         = r_err;
    assign o_tc          = (r_state == StRun) && !i_pause && w_last;
endmodule

// File: tb/tb_modn_count_ctrl.sv
// Self-checking bench for modn_count_ctrl: table-driven runs, hand-written
// corner sequences and randomized traffic against a progress-based model.
module tb_modn_count_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause, abort;
    logic [2:0] count;
    logic       tc, busy, done, err;

    int checks = 0;
    int errors = 0;

    // Model: run progress is the number of unpaused RUN cycles since accept.
    int m_st;    // 0 idle, 1 run, 2 done
    int m_mod, m_wraps, m_steps, m_err;

    // Last sampled DUT outputs for sequence bookkeeping.
    logic g_tc, g_done;

    typedef struct {
        int mod;
        int wraps;
        int exp_done_at;
        int exp_tc;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    modn_count_ctrl_if #(.WIDTH(3), .WRAP_W(8)) cmd_if ();

    modn_count_ctrl #(.WIDTH(3), .WRAP_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd_if),
        .i_pause (pause),
        .i_abort (abort),
        .o_count (count),
        .o_tc    (tc),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_err   = 0;
        m_steps = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs to model, advance model.
    task automatic cycle(input logic v, input int m, input int w, input logic p, input logic a);
        int exp_cnt, exp_tc;
        @(negedge clk);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_mod   = 3'(m);
        cmd_if.cmd_wraps = 8'(w);
        pause            = p;
        abort            = a;
        #1;
        exp_cnt = (m_st == 1) ? (m_steps % m_mod) : 0;
        exp_tc  = (m_st == 1 && !p && exp_cnt == m_mod - 1) ? 1 : 0;
        chk("count", int'(count), exp_cnt);
        chk("tc", int'(tc), exp_tc);
        chk("busy", int'(busy), (m_st == 1) ? 1 : 0);
        chk("done", int'(done), (m_st == 2) ? 1 : 0);
        chk("err", int'(err), m_err);
        chk("cmd_ready", int'(cmd_if.cmd_ready), (m_st == 0) ? 1 : 0);
        g_tc   = tc;
        g_done = done;
        m_err  = 0;
        case (m_st)
            0: if (v) begin
                if (m < 2) m_err = 1;
                else begin
                    m_mod = m; m_wraps = w; m_steps = 0; m_st = 1;
                end
            end
            1: if (a) m_st = 0;
               else if (!p) begin
                   m_steps++;
                   if (m_wraps != 0 && m_steps == m_mod * m_wraps) m_st = 2;
               end
            default: m_st = 0;
        endcase
    endtask

    initial begin
        int done_at, tcs;
        vecs[0] = '{mod: 6, wraps: 2, exp_done_at: 13, exp_tc: 2};
        vecs[1] = '{mod: 7, wraps: 3, exp_done_at: 22, exp_tc: 3};
        vecs[2] = '{mod: 2, wraps: 1, exp_done_at: 3,  exp_tc: 1};
        vecs[3] = '{mod: 3, wraps: 4, exp_done_at: 13, exp_tc: 4};
        vecs[4] = '{mod: 5, wraps: 1, exp_done_at: 6,  exp_tc: 1};
        vecs[5] = '{mod: 2, wraps: 3, exp_done_at: 7,  exp_tc: 3};

        rst_n = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_mod   = '0;
        cmd_if.cmd_wraps = '0;
        pause = 1'b0;
        abort = 1'b0;
        model_reset();
        #3;
        chk("reset count", int'(count), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset ready", int'(cmd_if.cmd_ready), 1);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset tc", int'(tc), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven nominal runs: done position and tc pulse count.
        for (int i = 0; i < 6; i++) begin
            done_at = 0;
            tcs     = 0;
            cycle(1'b1, vecs[i].mod, vecs[i].wraps, 1'b0, 1'b0);
            for (int k = 1; k <= 40; k++) begin
                cycle(1'b0, 0, 0, 1'b0, 1'b0);
                if (g_tc) tcs++;
                if (g_done && done_at == 0) done_at = k;
            end
            chk($sformatf("vec%0d done_at", i), done_at, vecs[i].exp_done_at);
            chk($sformatf("vec%0d tc_pulses", i), tcs, vecs[i].exp_tc);
        end

        // Pause for 3 cycles while count is 3: done slips from 7 to 10.
        done_at = 0;
        cycle(1'b1, 6, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 0, 0, (k >= 4 && k <= 6), 1'b0);
            if (k == 5) chk("pause hold count", int'(count), 3);
            if (g_done && done_at == 0) done_at = k;
        end
        chk("pause done_at", done_at, 10);

        // Abort on the terminal count of a free run.
        done_at = 0;
        cycle(1'b1, 5, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("abort tc seen", int'(g_tc), 1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 0, 0, 1'b0, 1'b0);
            if (g_done) done_at = 1;
        end
        chk("abort no done", done_at, 0);

        // Illegal modulus: one-cycle err, ready stays high.
        cycle(1'b1, 1, 2, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("illegal err", int'(err), 1);
        chk("illegal ready", int'(cmd_if.cmd_ready), 1);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("illegal err cleared", int'(err), 0);

        // Command while busy is ignored: original mod 4 x 1 completes.
        done_at = 0;
        cycle(1'b1, 4, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cycle(k <= 3, 3, 1, 1'b0, 1'b0);
            if (g_done && done_at == 0) done_at = k;
        end
        chk("busy reject done_at", done_at, 5);

        // Reset mid-run takes effect without a clock edge.
        cycle(1'b1, 6, 2, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst count", int'(count), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst ready", int'(cmd_if.cmd_ready), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_at = 0;
        cycle(1'b1, 3, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 0, 0, 1'b0, 1'b0);
            if (g_done && done_at == 0) done_at = k;
        end
        chk("post reset done_at", done_at, 4);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
